// File: rtl/pipe_csel_adder_if.sv
// pipe_csel_adder_if: operand/result handshake bundle for pipe_csel_adder.
//   master : operand source + result sink (drives IN_VALID, A, B, C_IN, SUB, OUT_READY)
//   slave  : the adder (drives IN_READY, OUT_VALID, SUM, C_OUT[, OVF])
// Optional OVF signal exists only when PIPE_CSEL_ADDER_OVF_EN is defined.
interface pipe_csel_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_IN;
  logic             SUB;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] SUM;
  logic             C_OUT;
`ifdef PIPE_CSEL_ADDER_OVF_EN
  logic             OVF;

  modport master (
    output IN_VALID, A, B, C_IN, SUB, OUT_READY,
    input  IN_READY, OUT_VALID, SUM, C_OUT, OVF
  );
  modport slave (
    input  IN_VALID, A, B, C_IN, SUB, OUT_READY,
    output IN_READY, OUT_VALID, SUM, C_OUT, OVF
  );
`else
  modport master (
    output IN_VALID, A, B, C_IN, SUB, OUT_READY,
    input  IN_READY, OUT_VALID, SUM, C_OUT
  );
  modport slave (
    input  IN_VALID, A, B, C_IN, SUB, OUT_READY,
    output IN_READY, OUT_VALID, SUM, C_OUT
  );
`endif
endinterface

// File: rtl/pipe_csel_adder.sv
// pipe_csel_adder: pipelined carry-select adder/subtractor.
//   One segment of SEG_WIDTH bits is resolved per stage; NUM_SEG = WIDTH/SEG_WIDTH
//   stages, latency NUM_SEG, throughput one operation per cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of pipe_csel_adder_if (IN_VALID/IN_READY, A, B, C_IN, SUB,
//           OUT_VALID/OUT_READY, SUM, C_OUT[, OVF])
// Optional: define PIPE_CSEL_ADDER_OVF_EN to add the registered signed-overflow OVF.
module pipe_csel_adder #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned SEG_WIDTH    = 4,
  parameter bit          SUB_EN_PARAM = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  pipe_csel_adder_if.slave  bus
);

  localparam int unsigned NUM_SEG = WIDTH / SEG_WIDTH;
  localparam int unsigned LAST    = NUM_SEG - 1;
  localparam int unsigned SW1     = SEG_WIDTH + 1;

  // Reject widths that do not split into whole segments
  if ((WIDTH % SEG_WIDTH) != 0) begin : g_bad_width
    $error("pipe_csel_adder: WIDTH must be a multiple of SEG_WIDTH");
  end

  // Per-stage registers: operands ride along, resolved sum bits accumulate
  logic [WIDTH-1:0]   a_q [NUM_SEG];
  logic [WIDTH-1:0]   b_q [NUM_SEG];
  logic [WIDTH-1:0]   s_q [NUM_SEG];
  logic [WIDTH-1:0]   a_d [NUM_SEG];
  logic [WIDTH-1:0]   b_d [NUM_SEG];
  logic [WIDTH-1:0]   s_d [NUM_SEG];
  logic [NUM_SEG-1:0] c_q, c_d;
  logic [NUM_SEG-1:0] v_q, v_d;

  // Stage inputs: stage 0 from the bus, stage k from stage k-1
  logic [WIDTH-1:0]   src_a [NUM_SEG];
  logic [WIDTH-1:0]   src_b [NUM_SEG];
  logic [WIDTH-1:0]   src_s [NUM_SEG];
  logic [NUM_SEG-1:0] src_c, src_v;

  logic               adv;
  logic               sub_eff;
  logic [SEG_WIDTH:0] sum0, sum1;

  // Whole pipe moves only when the output slot is empty or being drained
  assign adv     = ~v_q[LAST] | bus.OUT_READY;
  assign sub_eff = SUB_EN_PARAM & bus.SUB;

  // Operand conditioning and stage-to-stage routing
  always_comb begin
    src_c = '0;
    src_v = '0;
    for (int k = 0; k < int'(NUM_SEG); k++) begin
      src_a[k] = '0;
      src_b[k] = '0;
      src_s[k] = '0;
    end
    // Subtract as A + ~B + 1; C_IN is ignored in that mode
    src_a[0] = bus.A;
    src_b[0] = sub_eff ? ~bus.B : bus.B;
    src_s[0] = '0;
    src_c[0] = sub_eff | bus.C_IN;
    src_v[0] = bus.IN_VALID;
    for (int k = 1; k < int'(NUM_SEG); k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = s_q[k-1];
      src_c[k] = c_q[k-1];
      src_v[k] = v_q[k-1];
    end
  end

  // Carry-select per segment: both carry-in cases precomputed, incoming carry picks
  always_comb begin
    sum0 = '0;
    sum1 = '0;
    c_d  = '0;
    v_d  = '0;
    for (int k = 0; k < int'(NUM_SEG); k++) begin
      a_d[k] = src_a[k];
      b_d[k] = src_b[k];
      s_d[k] = src_s[k];
      v_d[k] = src_v[k];
      sum0 = {1'b0, src_a[k][k*SEG_WIDTH +: SEG_WIDTH]}
           + {1'b0, src_b[k][k*SEG_WIDTH +: SEG_WIDTH]};
      sum1 = {1'b0, src_a[k][k*SEG_WIDTH +: SEG_WIDTH]}
           + {1'b0, src_b[k][k*SEG_WIDTH +: SEG_WIDTH]} + SW1'(1);
      s_d[k][k*SEG_WIDTH +: SEG_WIDTH] = src_c[k] ? sum1[SEG_WIDTH-1:0] : sum0[SEG_WIDTH-1:0];
      c_d[k] = src_c[k] ? sum1[SEG_WIDTH] : sum0[SEG_WIDTH];
    end
  end

  // Pipeline registers; the last stage doubles as the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NUM_SEG); k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q <= '0;
      v_q <= '0;
    end else if (adv) begin
      for (int k = 0; k < int'(NUM_SEG); k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
      c_q <= c_d;
      v_q <= v_d;
    end
  end

`ifdef PIPE_CSEL_ADDER_OVF_EN
  logic ovf_d, ovf_q;

  // Carry into the MSB is recovered as a^b^sum at that bit; overflow = cin_msb ^ cout
  assign ovf_d = a_d[LAST][WIDTH-1] ^ b_d[LAST][WIDTH-1] ^ s_d[LAST][WIDTH-1] ^ c_d[LAST];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.OVF = ovf_q;
`endif

  assign bus.IN_READY  = adv;
  assign bus.OUT_VALID = v_q[LAST];
  assign bus.SUM       = s_q[LAST];
  assign bus.C_OUT     = c_q[LAST];

endmodule

// File: tb/tb_pipe_csel_adder.sv
// tb_pipe_csel_adder: directed, table-driven bench for pipe_csel_adder
// (WIDTH=16, SEG_WIDTH=4, latency 4). Checks OVF too when PIPE_CSEL_ADDER_OVF_EN is set.
module tb_pipe_csel_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  localparam int NVEC = 13;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  pipe_csel_adder_if #(.WIDTH(16)) bus ();

  pipe_csel_adder #(
    .WIDTH       (16),
    .SEG_WIDTH   (4),
    .SUB_EN_PARAM(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Send one operation, then wait (bounded) for its result and check value and latency
  task automatic run_one(input vec_t v, input string tag);
    int lat;
    @(negedge clk);
    bus.A         = v.a;
    bus.B         = v.b;
    bus.C_IN      = v.cin;
    bus.SUB       = v.sub;
    bus.IN_VALID  = 1'b1;
    bus.OUT_READY = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(bus.IN_READY), 32'd1);
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    lat = 1;
    while (!bus.OUT_VALID && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_sum"}, 32'(bus.SUM), 32'(v.sum));
    check({tag, "_cout"}, 32'(bus.C_OUT), 32'(v.cout));
`ifdef PIPE_CSEL_ADDER_OVF_EN
    check({tag, "_ovf"}, 32'(bus.OVF), 32'(v.ovf));
`endif
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          sent;
    int          got;
    int          stall;
    int          cyc;
    logic [15:0] expq[$];
    vec_t        rv;

    //            a        b        cin   sub   sum      cout  ovf
    vecs[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0};
    vecs[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4]  = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[5]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[6]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[7]  = '{16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0};
    vecs[8]  = '{16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0};
    vecs[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[10] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[11] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};
    vecs[12] = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

    rst_n         = 1'b0;
    bus.IN_VALID  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.C_IN      = 1'b0;
    bus.SUB       = 1'b0;
    bus.OUT_READY = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    check("rst_sum", 32'(bus.SUM), 32'd0);
    check("rst_cout", 32'(bus.C_OUT), 32'd0);
`ifdef PIPE_CSEL_ADDER_OVF_EN
    check("rst_ovf", 32'(bus.OVF), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed single operations
    for (int i = 0; i < NVEC; i++) begin
      run_one(vecs[i], $sformatf("v%0d", i));
    end

    // Back-to-back stream with a 3-cycle output stall after the 2nd result
    sent  = 0;
    got   = 0;
    stall = 0;
    cyc   = 0;
    while (got < 8 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      bus.OUT_READY = (stall == 0);
      bus.IN_VALID  = (sent < 8);
      bus.A         = 16'(sent + 1);
      bus.B         = 16'(16'h0100 * (sent + 1));
      bus.C_IN      = 1'b0;
      bus.SUB       = 1'b0;
      #1;
      if (stall > 0) begin
        check("stall_in_ready", 32'(bus.IN_READY), 32'd0);
        check("stall_out_valid", 32'(bus.OUT_VALID), 32'd1);
        if (expq.size() > 0) check("stall_sum_held", 32'(bus.SUM), 32'(expq[0]));
        check("stall_cout_held", 32'(bus.C_OUT), 32'd0);
        stall--;
      end
      if (bus.IN_VALID && bus.IN_READY) begin
        expq.push_back(16'(16'h0101 * (sent + 1)));
        sent++;
      end
      if (bus.OUT_VALID && bus.OUT_READY) begin
        if (expq.size() == 0) begin
          check("b2b_spurious", 32'(bus.OUT_VALID), 32'd0);
        end else begin
          check($sformatf("b2b_sum%0d", got + 1), 32'(bus.SUM), 32'(expq.pop_front()));
          check($sformatf("b2b_cout%0d", got + 1), 32'(bus.C_OUT), 32'd0);
        end
        got++;
        if (got == 2) stall = 3;
      end
    end
    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b1;
    check("b2b_sent", 32'(sent), 32'd8);
    check("b2b_got", 32'(got), 32'd8);
    repeat (6) @(negedge clk);
    check("b2b_no_extra", 32'(bus.OUT_VALID), 32'd0);

    // Asynchronous reset with three operations in flight
    bus.OUT_READY = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      bus.IN_VALID = 1'b1;
      bus.A        = 16'(16'h0010 * (j + 1));
      bus.B        = 16'h0005;
      bus.C_IN     = 1'b0;
      bus.SUB      = 1'b0;
    end
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    @(negedge clk);
    check("inflight_valid", 32'(bus.OUT_VALID), 32'd1);
    check("inflight_sum", 32'(bus.SUM), 32'h0015);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.OUT_VALID), 32'd0);
    check("async_rst_sum", 32'(bus.SUM), 32'd0);
    check("async_rst_cout", 32'(bus.C_OUT), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.OUT_READY = 1'b1;
    rv = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
    run_one(rv, "post_rst");
    @(negedge clk);
    check("post_rst_empty", 32'(bus.OUT_VALID), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
